multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback over a shared ALU and a single shared instruction/data memory port. It drives the immediate-format select of the sign extender and all datapath mux and write enables. It also keeps a retired-instruction counter and flags unsupported opcodes.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; synchronous, active-high
- opcode_i  in  7  instr[6:0] from instruction register
- funct3_i  in  3  instr[14:12]
- funct7b5_i  in  1  instr[30]
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory accepts/completes current access this cycle
- mem_req_o  out  1  memory access request
- memwrite_o  out  1  access is a store
- adrsrc_o  out  1  0 = PC, 1 = ALUOut as memory address
- irwrite_o  out  1  load instruction register
- pcwrite_o  out  1  load PC
- regwrite_o  out  1  register file write
- immsrc_o  out  3  sign-extender format
- alusrca_o  out  2  0 PC, 1 oldPC, 2 rs1, 3 zero
- alusrcb_o  out  2  0 rs2, 1 ImmExt, 2 constant 4
- alucontrol_o  out  3  ALU operation
- resultsrc_o  out  2  0 ALUOut, 1 Data, 2 ALUResult
- illegal_o  out  1  sticky unsupported-opcode flag
- instret_o  out  CNT_W  retired instruction count

## Operation
- Supported instructions:
  - lw (0000011)
  - sw (0100011)
  - R-type (0110011)
  - I-ALU (0010011)
  - beq/bne (1100011)
  - jal (1101111)
  - lui (0110111)
- Any other opcode goes to TRAP.
- Moore FSM. Outputs depend only on state, plus zero_i/funct3_i in BRANCH and mem_ready_i in memory states. Unlisted outputs are 0.
- FETCH:
  - Asserts mem_req_o with adrsrc=0.
  - Holds until mem_ready_i.
  - In the ready cycle, also asserts irwrite, pcwrite, alusrca=0, alusrcb=2, add, resultsrc=2.
  - Then goes to DECODE.
- DECODE:
  - Computes oldPC+imm into ALUOut: alusrca=1, alusrcb=1, add, immsrc=010.
  - Dispatches on opcode.
- MEMADR: rs1+imm, with immsrc 000 (lw) or 001 (sw). Goes to MEMREAD or MEMWRITE.
- MEMREAD: mem_req, adrsrc=1. Holds until ready, then MEMWB.
- MEMWB: regwrite, resultsrc=1. Retires; then FETCH.
- MEMWRITE: mem_req, memwrite, adrsrc=1. Holds until ready, then retires; then FETCH.
- EXECUTER: rs1 op rs2, via the funct decode. Then ALUWB.
- EXECUTEI: rs1 op imm, immsrc=000. Then ALUWB.
- ALUWB: regwrite, resultsrc=0. Retires; then FETCH.
- BRANCH:
  - Compare using alusrca=2, alusrcb=0, sub, resultsrc=0 (target held in ALUOut).
  - pcwrite = zero_i when funct3=000, and !zero_i when funct3=001.
  - Any other funct3 goes to TRAP.
  - Retires; then FETCH.
- JAL:
  - alusrca=1, alusrcb=2, add (oldPC+4).
  - pcwrite with resultsrc=0, immsrc=011 (ALUOut = target from DECODE).
  - Then ALUWB.
- LUI: alusrca=3, alusrcb=1, immsrc=100, add. Then ALUWB.
- TRAP:
  - Sets illegal_o; stays until reset.
  - No enables asserted; instret frozen.
- ALU decode (alucontrol encoding):
  - Encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
  - funct3 mapping: 000 → add, or sub when R-type and funct7b5=1. 010 → slt. 100 → xor. 110 → or. 111 → and.
  - Other funct3 values in EXECUTER/EXECUTEI go to TRAP.
- instret_o:
  - Increments by 1 in each retiring cycle.
  - Wraps modulo 2^CNT_W.

## Timing
- Reset:
  - rst_i high at a clock edge sets state=FETCH, instret=0, illegal=0.
  - While rst_i is high, all enables and mem_req_o are forced to 0 and immsrc_o=000.
  - Reset aborts any in-flight access and overrides mem_ready_i in the same cycle.
- Latency, with mem_ready_i high on first request:
  - lw 5 cycles
  - sw 4, R/I 4, jal 4, lui 4
  - branch 3
- Each wait cycle on mem_ready_i adds one cycle.
- mem_req_o, adrsrc_o and memwrite_o stay stable while waiting. All write enables stay 0 until the ready cycle.
- irwrite/pcwrite in FETCH occur only in the ready cycle, never twice for one fetch.
- At most one of regwrite_o and memwrite_o is high in any cycle.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams
  - immsrc encoding: IMM_I=000, IMM_S=001, IMM_B=010, IMM_J=011, IMM_U=100
  - alucontrol encoding
  - the state enum typedef
- Sub-module alu_decoder (combinational): funct3, funct7b5, R/I class → alucontrol, valid.

## Test plan
- Reset mid-MEMREAD, with mem_ready_i high that cycle → next cycle FETCH, regwrite=0, instret=0.
- add x3,x1,x2 (0x002081B3), ready every cycle → 4 cycles; alucontrol 000 in EXECUTER; regwrite in cycle 4; instret 0→1.
- lw, with mem_ready_i low for 3 cycles in MEMREAD → 8 cycles; immsrc 000 in MEMADR; adrsrc=1 held throughout.
- beq with zero_i=1, then bne with zero_i=1 → pcwrite high in BRANCH for beq only; each takes 3 cycles.
- jal then lui → immsrc 010 in DECODE, 011 in JAL, 100 in LUI; regwrite in ALUWB.
- Opcode 0x7F → TRAP; illegal_o=1 held; no enables for 20 cycles; cleared by reset.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, datapath
// mux selects, immediate formats, ALU operations and the controller states.
package ctrl_pkg;

    // Supported major opcodes (instr[6:0])
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // Sign-extender format select
    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;

    // ALU operation encoding
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU source A select
    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    // ALU source B select
    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_DATA   = 2'd1;
    localparam logic [1:0] RES_ALURES = 2'd2;

    // Branch funct3 values handled by the core
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // Bundle of every datapath control the FSM drives
    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       adrsrc;
        logic       irwrite;
        logic       pcwrite;
        logic       regwrite;
        logic [2:0] immsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic [1:0] resultsrc;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from funct3/funct7b5. The subtract form
// of funct3=000 exists only for R-type; immediates always add. Unsupported
// funct3 values report valid=0 so the FSM can trap.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alucontrol,
    output logic       valid
);

    // Map funct3 (and funct7b5 for R-type) onto the ALU operation code
    always_comb begin
        alucontrol = ALU_ADD;
        valid      = 1'b1;
        case (funct3)
            3'b000: begin
                if (is_rtype && funct7b5) begin
                    alucontrol = ALU_SUB;
                end else begin
                    alucontrol = ALU_ADD;
                end
            end
            3'b010:  alucontrol = ALU_SLT;
            3'b100:  alucontrol = ALU_XOR;
            3'b110:  alucontrol = ALU_OR;
            3'b111:  alucontrol = ALU_AND;
            default: begin
                alucontrol = ALU_ADD;
                valid      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. Sequences fetch, decode,
// execute, memory and writeback over a shared ALU and one memory port,
// counts retired instructions and traps on unsupported encodings.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7b5_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             memwrite_o,
    output logic             adrsrc_o,
    output logic             irwrite_o,
    output logic             pcwrite_o,
    output logic             regwrite_o,
    output logic [2:0]       immsrc_o,
    output logic [1:0]       alusrca_o,
    output logic [1:0]       alusrcb_o,
    output logic [2:0]       alucontrol_o,
    output logic [1:0]       resultsrc_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           next_s;
    ctrl_t            ctrl_s;
    ctrl_t            ctrl_out_s;
    logic             retire_s;
    logic             is_rtype_s;
    logic [2:0]       dec_alu_s;
    logic             dec_valid_s;
    logic [CNT_W-1:0] instret_r;
    logic             illegal_r;

    assign is_rtype_s = (state_r == S_EXECR);

    alu_decoder u_alu_decoder (
        .funct3     (funct3_i),
        .funct7b5   (funct7b5_i),
        .is_rtype   (is_rtype_s),
        .alucontrol (dec_alu_s),
        .valid      (dec_valid_s)
    );

    // State register; reset wins over any in-flight memory handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and Moore outputs (plus zero/funct3 in BRANCH, ready in memory states)
    always_comb begin
        next_s   = state_r;
        ctrl_s   = '0;
        retire_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.adrsrc  = 1'b0;
                if (mem_ready_i) begin
                    ctrl_s.irwrite    = 1'b1;
                    ctrl_s.pcwrite    = 1'b1;
                    ctrl_s.alusrca    = SRCA_PC;
                    ctrl_s.alusrcb    = SRCB_FOUR;
                    ctrl_s.alucontrol = ALU_ADD;
                    ctrl_s.resultsrc  = RES_ALURES;
                    next_s            = S_DECODE;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch/jump target oldPC+imm is parked in ALUOut here
                ctrl_s.alusrca    = SRCA_OLDPC;
                ctrl_s.alusrcb    = SRCB_IMM;
                ctrl_s.alucontrol = ALU_ADD;
                ctrl_s.immsrc     = IMM_B;
                case (opcode_i)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_R:         next_s = S_EXECR;
                    OP_I:         next_s = S_EXECI;
                    OP_BR:        next_s = S_BRANCH;
                    OP_JAL:       next_s = S_JAL;
                    OP_LUI:       next_s = S_LUI;
                    default:      next_s = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ctrl_s.alusrca    = SRCA_RS1;
                ctrl_s.alusrcb    = SRCB_IMM;
                ctrl_s.alucontrol = ALU_ADD;
                if (opcode_i == OP_SW) begin
                    ctrl_s.immsrc = IMM_S;
                    next_s        = S_MEMWRITE;
                end else begin
                    ctrl_s.immsrc = IMM_I;
                    next_s        = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.adrsrc  = 1'b1;
                if (mem_ready_i) begin
                    next_s = S_MEMWB;
                end else begin
                    next_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                ctrl_s.regwrite  = 1'b1;
                ctrl_s.resultsrc = RES_DATA;
                retire_s         = 1'b1;
                next_s           = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl_s.mem_req  = 1'b1;
                ctrl_s.memwrite = 1'b1;
                ctrl_s.adrsrc   = 1'b1;
                if (mem_ready_i) begin
                    retire_s = 1'b1;
                    next_s   = S_FETCH;
                end else begin
                    next_s = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                ctrl_s.alusrca    = SRCA_RS1;
                ctrl_s.alusrcb    = SRCB_RS2;
                ctrl_s.alucontrol = dec_alu_s;
                if (dec_valid_s) begin
                    next_s = S_ALUWB;
                end else begin
                    next_s = S_TRAP;
                end
            end
            S_EXECI: begin
                ctrl_s.alusrca    = SRCA_RS1;
                ctrl_s.alusrcb    = SRCB_IMM;
                ctrl_s.immsrc     = IMM_I;
                ctrl_s.alucontrol = dec_alu_s;
                if (dec_valid_s) begin
                    next_s = S_ALUWB;
                end else begin
                    next_s = S_TRAP;
                end
            end
            S_ALUWB: begin
                ctrl_s.regwrite  = 1'b1;
                ctrl_s.resultsrc = RES_ALUOUT;
                retire_s         = 1'b1;
                next_s           = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_s.alusrca    = SRCA_RS1;
                ctrl_s.alusrcb    = SRCB_RS2;
                ctrl_s.alucontrol = ALU_SUB;
                ctrl_s.resultsrc  = RES_ALUOUT;
                case (funct3_i)
                    F3_BEQ: begin
                        ctrl_s.pcwrite = zero_i;
                        retire_s       = 1'b1;
                        next_s         = S_FETCH;
                    end
                    F3_BNE: begin
                        ctrl_s.pcwrite = ~zero_i;
                        retire_s       = 1'b1;
                        next_s         = S_FETCH;
                    end
                    default: begin
                        next_s = S_TRAP;
                    end
                endcase
            end
            S_JAL: begin
                // Link value oldPC+4 on the ALU; PC takes the target from ALUOut
                ctrl_s.alusrca    = SRCA_OLDPC;
                ctrl_s.alusrcb    = SRCB_FOUR;
                ctrl_s.alucontrol = ALU_ADD;
                ctrl_s.resultsrc  = RES_ALUOUT;
                ctrl_s.immsrc     = IMM_J;
                ctrl_s.pcwrite    = 1'b1;
                next_s            = S_ALUWB;
            end
            S_LUI: begin
                ctrl_s.alusrca    = SRCA_ZERO;
                ctrl_s.alusrcb    = SRCB_IMM;
                ctrl_s.immsrc     = IMM_U;
                ctrl_s.alucontrol = ALU_ADD;
                next_s            = S_ALUWB;
            end
            S_TRAP: begin
                next_s = S_TRAP;
            end
            default: begin
                // Unreachable encodings fall into the safe trap state
                next_s = S_TRAP;
            end
        endcase
    end

    // Reset silences every enable and the memory request in the same cycle
    always_comb begin
        if (rst_i) begin
            ctrl_out_s = '0;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + CNT_ONE;
        end else begin
            instret_r <= instret_r;
        end
    end

    // Sticky illegal flag, raised on entry to TRAP and cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_r <= 1'b0;
        end else if (next_s == S_TRAP) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign mem_req_o    = ctrl_out_s.mem_req;
    assign memwrite_o   = ctrl_out_s.memwrite;
    assign adrsrc_o     = ctrl_out_s.adrsrc;
    assign irwrite_o    = ctrl_out_s.irwrite;
    assign pcwrite_o    = ctrl_out_s.pcwrite;
    assign regwrite_o   = ctrl_out_s.regwrite;
    assign immsrc_o     = ctrl_out_s.immsrc;
    assign alusrca_o    = ctrl_out_s.alusrca;
    assign alusrcb_o    = ctrl_out_s.alusrcb;
    assign alucontrol_o = ctrl_out_s.alucontrol;
    assign resultsrc_o  = ctrl_out_s.resultsrc;
    assign illegal_o    = illegal_r;
    assign instret_o    = instret_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus queues the hand-derived
// expected control vector for every cycle it drives, and a negedge monitor
// pops and compares against the DUT outputs.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
    logic [2:0]  immsrc;
    logic [1:0]  alusrca, alusrcb;
    logic [2:0]  alucontrol;
    logic [1:0]  resultsrc;
    logic        illegal;
    logic [31:0] instret;

    typedef struct packed {
        logic        mr, mw, as, ir, pw, rw;
        logic [2:0]  imm;
        logic [1:0]  sa, sb;
        logic [2:0]  ac;
        logic [1:0]  rs;
        logic        ill;
        logic [31:0] cnt;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        act_v;
    obs_t        exp_v;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_idx = 0;
    logic        exp_ill;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .opcode_i     (opcode),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .mem_req_o    (mem_req),
        .memwrite_o   (memwrite),
        .adrsrc_o     (adrsrc),
        .irwrite_o    (irwrite),
        .pcwrite_o    (pcwrite),
        .regwrite_o   (regwrite),
        .immsrc_o     (immsrc),
        .alusrca_o    (alusrca),
        .alusrcb_o    (alusrcb),
        .alucontrol_o (alucontrol),
        .resultsrc_o  (resultsrc),
        .illegal_o    (illegal),
        .instret_o    (instret)
    );

    // Monitor: compare the DUT against the next queued expectation mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
                     immsrc, alusrca, alusrcb, alucontrol, resultsrc, illegal, instret};
            n_cmp = n_cmp + 1;
            if (act_v !== exp_v) begin
                n_bad = n_bad + 1;
                $display("FAIL ctrl_cycle_%0d: got mr%b mw%b as%b ir%b pw%b rw%b imm%b sa%0d sb%0d ac%b rs%0d ill%b cnt%0d, want mr%b mw%b as%b ir%b pw%b rw%b imm%b sa%0d sb%0d ac%b rs%0d ill%b cnt%0d",
                         cyc_idx,
                         act_v.mr, act_v.mw, act_v.as, act_v.ir, act_v.pw, act_v.rw, act_v.imm,
                         act_v.sa, act_v.sb, act_v.ac, act_v.rs, act_v.ill, act_v.cnt,
                         exp_v.mr, exp_v.mw, exp_v.as, exp_v.ir, exp_v.pw, exp_v.rw, exp_v.imm,
                         exp_v.sa, exp_v.sb, exp_v.ac, exp_v.rs, exp_v.ill, exp_v.cnt);
            end
            cyc_idx = cyc_idx + 1;
        end
    end

    // Queue the expected outputs for the current cycle, then advance one clock
    task automatic chk(input logic mr, input logic mw, input logic as, input logic ir,
                       input logic pw, input logic rw, input logic [2:0] imm,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] ac,
                       input logic [1:0] rs);
        obs_t e;
        e.mr = mr;  e.mw = mw; e.as = as; e.ir = ir; e.pw = pw; e.rw = rw;
        e.imm = imm; e.sa = sa; e.sb = sb; e.ac = ac; e.rs = rs;
        e.ill = exp_ill;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic c_idle();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 2'd0, 3'b000, 2'd0);
    endtask
    task automatic c_fetch_wait();
        chk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 2'd0, 3'b000, 2'd0);
    endtask
    task automatic c_fetch_rdy();
        chk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 2'd2, 3'b000, 2'd2);
    endtask
    task automatic c_decode();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1, 2'd1, 3'b000, 2'd0);
    endtask
    task automatic c_aluwb();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'd0, 2'd0, 3'b000, 2'd0);
    endtask
    task automatic c_memadr(input logic [2:0] imm);
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, imm, 2'd2, 2'd1, 3'b000, 2'd0);
    endtask
    task automatic c_memread();
        chk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 2'd0, 3'b000, 2'd0);
    endtask

    initial begin
        rst = 1'b1; opcode = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1; exp_ill = 1'b0; exp_cnt = 32'd0;
        @(posedge clk);
        #1;
        c_idle();                                       // reset cycle
        rst = 1'b0;

        // add x3,x1,x2 (0x002081B3)
        opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        c_fetch_rdy(); c_decode();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd2, 2'd0, 3'b000, 2'd0);
        c_aluwb(); exp_cnt = 32'd1;

        // sub (funct7b5=1)
        funct7b5 = 1'b1;
        c_fetch_rdy(); c_decode();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd2, 2'd0, 3'b001, 2'd0);
        c_aluwb(); exp_cnt = 32'd2;

        // xori with instr[30] set: still xor, immediate path
        opcode = 7'b0010011; funct3 = 3'b100;
        c_fetch_rdy(); c_decode();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd2, 2'd1, 3'b100, 2'd0);
        c_aluwb(); exp_cnt = 32'd3;

        // lw with three wait cycles in MEMREAD -> 8 cycles
        opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        c_fetch_rdy(); c_decode(); c_memadr(3'b000);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) c_memread();
        mem_ready = 1'b1;
        c_memread();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'd0, 2'd0, 3'b000, 2'd1);
        exp_cnt = 32'd4;

        // sw with one fetch wait and one store wait
        opcode = 7'b0100011;
        mem_ready = 1'b0; c_fetch_wait();
        mem_ready = 1'b1; c_fetch_rdy(); c_decode(); c_memadr(3'b001);
        mem_ready = 1'b0;
        chk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 2'd0, 3'b000, 2'd0);
        mem_ready = 1'b1;
        chk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 2'd0, 3'b000, 2'd0);
        exp_cnt = 32'd5;

        // beq taken, bne not taken, bne taken
        opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        c_fetch_rdy(); c_decode();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2'd2, 2'd0, 3'b001, 2'd0);
        exp_cnt = 32'd6;
        funct3 = 3'b001;
        c_fetch_rdy(); c_decode();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd2, 2'd0, 3'b001, 2'd0);
        exp_cnt = 32'd7;
        zero = 1'b0;
        c_fetch_rdy(); c_decode();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2'd2, 2'd0, 3'b001, 2'd0);
        exp_cnt = 32'd8;

        // jal then lui
        opcode = 7'b1101111; funct3 = 3'b000;
        c_fetch_rdy(); c_decode();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 2'd1, 2'd2, 3'b000, 2'd0);
        c_aluwb(); exp_cnt = 32'd9;
        opcode = 7'b0110111;
        c_fetch_rdy(); c_decode();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 2'd3, 2'd1, 3'b000, 2'd0);
        c_aluwb(); exp_cnt = 32'd10;

        // reset in MEMREAD while memory reports ready
        opcode = 7'b0000011; funct3 = 3'b010;
        c_fetch_rdy(); c_decode(); c_memadr(3'b000);
        mem_ready = 1'b0; c_memread();
        rst = 1'b1; mem_ready = 1'b1; c_idle();
        rst = 1'b0; mem_ready = 1'b0; exp_cnt = 32'd0;
        c_fetch_wait();

        // I-type with unsupported funct3 traps after EXECUTEI
        mem_ready = 1'b1; opcode = 7'b0010011; funct3 = 3'b001;
        c_fetch_rdy(); c_decode();
        chk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd2, 2'd1, 3'b000, 2'd0);
        exp_ill = 1'b1;
        c_idle(); c_idle();
        rst = 1'b1; c_idle();
        rst = 1'b0; exp_ill = 1'b0;

        // opcode 0x7F: TRAP, sticky flag, no enables for 20 cycles
        opcode = 7'b1111111; funct3 = 3'b000;
        c_fetch_rdy(); c_decode();
        exp_ill = 1'b1;
        for (int i = 0; i < 20; i++) begin
            zero = i[0];
            c_idle();
        end
        rst = 1'b1; c_idle();
        rst = 1'b0; exp_ill = 1'b0; mem_ready = 1'b0;
        c_fetch_wait();

        @(negedge clk);
        #1;
        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
